// File: rtl/duty_ramp_controller.sv
// Duty slew controller between the host speed command and the BLDC driver.
// Duty moves toward the commanded value one fixed step per prescaler period.
// A direction change or a disable first ramps duty down to zero, then coasts
// with the gate off before any restart. A driver fault forces a safe stop
// that only clears once the host has also dropped its enable.
//
// Direction encoding: 2'd0 = none (stop), 2'd1 = CW, 2'd2 = CCW. Code 2'd3
// is never a valid start request and is treated like "none".
//
//   state | meaning
//   IDLE  | gate off, waiting for a run request
//   RAMP  | gate on, duty slewing toward the effective target
//   COAST | gate off after reaching zero duty, dwell before restart
//   FAULT | gate off, latched until fault clears and enable drops
module duty_ramp_controller #(
  parameter int clk_freq_hz       = 54_000_000,
  parameter int pwm_counter_width = 11,
  parameter int ramp_step_us      = 100,
  parameter int duty_step         = 8,
  parameter int coast_us          = 20_000
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         cmd_enable_i,
  input  logic [1:0]                   cmd_direction_i,
  input  logic [pwm_counter_width-1:0] cmd_duty_i,
  input  logic                         fault_i,
  output logic                         drv_enable_o,
  output logic [1:0]                   drv_direction_o,
  output logic [pwm_counter_width-1:0] drv_duty_o,
  output logic                         at_target_o,
  output logic [1:0]                   ramp_state_o
);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_CCW  = 2'd2;

  localparam int dw            = pwm_counter_width;
  localparam int dwx           = pwm_counter_width + 1;
  localparam int cycles_per_us = clk_freq_hz / 1_000_000;
  localparam int step_raw      = cycles_per_us * ramp_step_us;
  localparam int coast_raw     = cycles_per_us * coast_us;
  localparam int step_cycles   = (step_raw < 1) ? 1 : step_raw;
  localparam int coast_cycles  = (coast_raw < 1) ? 1 : coast_raw;
  localparam int psc_w         = $clog2(step_cycles + 1);
  localparam int cst_w         = $clog2(coast_cycles + 1);

  localparam logic [psc_w-1:0] psc_last = psc_w'(step_cycles - 1);
  localparam logic [cst_w-1:0] cst_last = cst_w'(coast_cycles - 1);
  localparam logic [dwx-1:0]   step_ext = dwx'(duty_step);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_COAST = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              drv_enable_q, drv_enable_d;
  logic [1:0]        drv_dir_q, drv_dir_d;
  logic [dw-1:0]     drv_duty_q, drv_duty_d;
  logic              at_target_q, at_target_d;
  logic [psc_w-1:0]  presc_q, presc_d;
  logic [cst_w-1:0]  coast_q, coast_d;

  logic [dw-1:0]     eff_duty;
  logic [dw-1:0]     duty_stepped;
  logic [dwx-1:0]    duty_ext;
  logic [dwx-1:0]    eff_ext;
  logic [dwx-1:0]    up_sum;
  logic [dwx-1:0]    gap_down;
  logic              strobe;
  logic              start_req;

  // Effective target: a direction mismatch or a dropped enable slews to zero.
  always_comb begin
    eff_duty  = '0;
    if (cmd_enable_i && (cmd_direction_i == drv_dir_q)) begin
      eff_duty = cmd_duty_i;
    end
    start_req = cmd_enable_i &&
                ((cmd_direction_i == DIR_CW) || (cmd_direction_i == DIR_CCW));
    strobe    = (presc_q == psc_last);
  end

  // One clamped duty step toward the target, computed one bit wider so
  // neither the top of the range nor zero can wrap.
  always_comb begin
    duty_ext     = {1'b0, drv_duty_q};
    eff_ext      = {1'b0, eff_duty};
    up_sum       = duty_ext + step_ext;
    gap_down     = duty_ext - eff_ext;
    duty_stepped = drv_duty_q;
    if (duty_ext < eff_ext) begin
      if (up_sum >= eff_ext) begin
        duty_stepped = eff_duty;
      end else begin
        duty_stepped = up_sum[dw-1:0];
      end
    end else if (duty_ext > eff_ext) begin
      if (gap_down <= step_ext) begin
        duty_stepped = eff_duty;
      end else begin
        duty_stepped = drv_duty_q - step_ext[dw-1:0];
      end
    end
  end

  // Next-state and next-output decode; a fault overrides every state.
  always_comb begin
    state_d      = state_q;
    drv_enable_d = drv_enable_q;
    drv_dir_d    = drv_dir_q;
    drv_duty_d   = drv_duty_q;
    presc_d      = presc_q;
    coast_d      = coast_q;

    case (state_q)
      ST_IDLE: begin
        drv_enable_d = 1'b0;
        drv_dir_d    = DIR_NONE;
        drv_duty_d   = '0;
        if (start_req) begin
          state_d      = ST_RAMP;
          drv_enable_d = 1'b1;
          drv_dir_d    = cmd_direction_i;
          presc_d      = '0;
        end
      end

      ST_RAMP: begin
        if ((drv_duty_q == '0) && (eff_duty == '0)) begin
          state_d      = ST_COAST;
          drv_enable_d = 1'b0;
          drv_dir_d    = DIR_NONE;
          drv_duty_d   = '0;
          coast_d      = cst_last;
        end else if (strobe) begin
          presc_d    = '0;
          drv_duty_d = duty_stepped;
        end else begin
          presc_d = presc_q + psc_w'(1);
        end
      end

      ST_COAST: begin
        drv_enable_d = 1'b0;
        drv_dir_d    = DIR_NONE;
        drv_duty_d   = '0;
        if (coast_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          coast_d = coast_q - cst_w'(1);
        end
      end

      ST_FAULT: begin
        drv_enable_d = 1'b0;
        drv_dir_d    = DIR_NONE;
        drv_duty_d   = '0;
        if (!fault_i && !cmd_enable_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_FAULT;
        drv_enable_d = 1'b0;
        drv_dir_d    = DIR_NONE;
        drv_duty_d   = '0;
      end
    endcase

    if (fault_i) begin
      state_d      = ST_FAULT;
      drv_enable_d = 1'b0;
      drv_dir_d    = DIR_NONE;
      drv_duty_d   = '0;
    end

    // Registered alongside the duty so the flag lines up with drv_duty_o.
    at_target_d = (state_d == ST_RAMP) && cmd_enable_i &&
                  (drv_duty_d == cmd_duty_i) &&
                  (cmd_direction_i == drv_dir_d);
  end

  // State, outputs and timers; reset drops the gate immediately.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      drv_enable_q <= 1'b0;
      drv_dir_q    <= DIR_NONE;
      drv_duty_q   <= '0;
      at_target_q  <= 1'b0;
      presc_q      <= '0;
      coast_q      <= '0;
    end else begin
      state_q      <= state_d;
      drv_enable_q <= drv_enable_d;
      drv_dir_q    <= drv_dir_d;
      drv_duty_q   <= drv_duty_d;
      at_target_q  <= at_target_d;
      presc_q      <= presc_d;
      coast_q      <= coast_d;
    end
  end

  assign drv_enable_o    = drv_enable_q;
  assign drv_direction_o = drv_dir_q;
  assign drv_duty_o      = drv_duty_q;
  assign at_target_o     = at_target_q;
  assign ramp_state_o    = state_q;

endmodule
